// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - calculator keypad keycodes, key map and scanner state type
package calc_pkg;

    localparam logic [3:0] KEY_CLR = 4'd10;
    localparam logic [3:0] KEY_EQ  = 4'd11;
    localparam logic [3:0] KEY_DIV = 4'd12;
    localparam logic [3:0] KEY_MUL = 4'd13;
    localparam logic [3:0] KEY_SUB = 4'd14;
    localparam logic [3:0] KEY_ADD = 4'd15;

    // Indexed KEYMAP[row][col]; ascending ranges keep the literal in reading order.
    localparam logic [0:3][0:3][3:0] KEYMAP = {
        4'd1,    4'd2, 4'd3,   KEY_ADD,
        4'd4,    4'd5, 4'd6,   KEY_SUB,
        4'd7,    4'd8, 4'd9,   KEY_MUL,
        KEY_CLR, 4'd0, KEY_EQ, KEY_DIV
    };

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} scan_state_t;

    function automatic logic [1:0] lowest_low_col(input logic [3:0] col_n);
        if (!col_n[0])      return 2'd0;
        else if (!col_n[1]) return 2'd1;
        else if (!col_n[2]) return 2'd2;
        else                return 2'd3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       keystrobe,
    output logic [3:0] keycode
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    scan_state_t   r_state, w_state_nxt;
    logic [1:0]    r_row, w_row_nxt;
    logic [1:0]    r_col, w_col_nxt;
    logic [SW-1:0] r_scan_cnt, w_scan_cnt_nxt;
    logic [DW-1:0] r_deb_cnt, w_deb_cnt_nxt;
    logic [3:0]    r_row_n;
    logic          r_keystrobe, w_strobe_nxt;
    logic [3:0]    r_keycode, w_keycode_nxt;
    logic [3:0]    w_colsync_n;
    logic          w_driving;
    logic          w_key_up;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (col_n),
        .o_q     (w_colsync_n)
    );

    // The dwell count only starts once a row is actually on the pins.
    assign w_driving = ~&r_row_n;
    assign w_key_up  = w_colsync_n[r_col];

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_scan_cnt_nxt = r_scan_cnt;
        w_deb_cnt_nxt  = r_deb_cnt;
        w_strobe_nxt   = 1'b0;
        w_keycode_nxt  = r_keycode;
        case (r_state)
            SCAN: begin
                if (w_driving) begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        w_scan_cnt_nxt = '0;
                        if (&w_colsync_n) begin
                            w_row_nxt = r_row + 2'd1;
                        end else begin
                            w_col_nxt     = lowest_low_col(w_colsync_n);
                            w_deb_cnt_nxt = '0;
                            w_state_nxt   = DEB_PRESS;
                        end
                    end else begin
                        w_scan_cnt_nxt = r_scan_cnt + 1'b1;
                    end
                end
            end
            DEB_PRESS: begin
                if (!w_key_up) begin
                    if (r_deb_cnt == DEB_LAST) begin
                        w_strobe_nxt  = 1'b1;
                        w_keycode_nxt = KEYMAP[r_row][r_col];
                        w_state_nxt   = HELD;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                    end
                end else begin
                    w_row_nxt      = r_row + 2'd1;
                    w_scan_cnt_nxt = '0;
                    w_state_nxt    = SCAN;
                end
            end
            HELD: begin
                if (w_key_up) begin
                    w_deb_cnt_nxt = '0;
                    w_state_nxt   = DEB_REL;
                end
            end
            DEB_REL: begin
                if (w_key_up) begin
                    if (r_deb_cnt == DEB_LAST) begin
                        w_row_nxt      = r_row + 2'd1;
                        w_scan_cnt_nxt = '0;
                        w_state_nxt    = SCAN;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                    end
                end else begin
                    w_deb_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SCAN;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_scan_cnt  <= '0;
            r_deb_cnt   <= '0;
            r_row_n     <= 4'b1111;
            r_keystrobe <= 1'b0;
            r_keycode   <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_scan_cnt  <= w_scan_cnt_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_row_n     <= ~(4'b0001 << w_row_nxt);
            r_keystrobe <= w_strobe_nxt;
            r_keycode   <= w_keycode_nxt;
        end
    end

    assign row_n     = r_row_n;
    assign keystrobe = r_keystrobe;
    assign keycode   = r_keycode;

endmodule
